pc_fetch_unit: RTL
==================

# pc_fetch_unit

Program-counter and instruction-fetch control for the pipeline; the consumer end of the branching redirect interface. Takes the flush/hold/bypass/branch/PCnext/PCcurrent redirect bundle, maintains the PC, issues single-outstanding requests to instruction memory and fills the IF/DEC register, including bubbles. Sits between instruction memory and decode.

## Interface
- RESET_PC, 32'h0000_0000, PC fetched first after reset
- NOP_INSTR, 32'h0000_0013, bubble instruction (addi x0,x0,0)
- Clock  in  1  core clock, all state on posedge
- Reset  in  1  synchronous, active-high reset
- flush  in  1  kill the instruction currently in IF/DEC and any in-flight fetch
- hold  in  1  stall PC, insert bubble into IF/DEC
- bypass  in  1  absolute redirect: target = PCnext
- branch  in  1  relative redirect: target = PCcurrent + PCnext
- PCnext  in  32  target or offset
- PCcurrent  in  32  base PC for relative redirect
- imemReq  out  1  fetch request, one cycle pulse
- imemAddr  out  32  fetch address, valid with imemReq
- imemValid  in  1  response strobe, ≥1 cycle after imemReq
- imemRdata  in  32  instruction, valid with imemValid
- PCIF  out  32  PC of instruction in IF/DEC
- instrIF  out  32  IF/DEC instruction
- validIF  out  1  instrIF is a real instruction (0 = bubble)
- misalignTrap  out  1  see Configuration

## Operation
- Redirect priority: bypass > branch > sequential. Target = bypass ? PCnext : PCcurrent + PCnext (32-bit wrap, carry discarded).
- FSM states: ISSUE, WAIT, KILL, HALT.
- ISSUE: assert imemReq with imemAddr = pc; go WAIT. If hold is high, no request; stay ISSUE.
- WAIT: on imemValid, load IF/DEC {PCIF=pc, instrIF=imemRdata, validIF=1}, pc <= pc+4, go ISSUE. Without imemValid, IF/DEC holds bubble (validIF=0, instrIF=NOP_INSTR).
- Redirect (bypass or branch) in any state: pc <= target. In WAIT without imemValid the in-flight response is stale: go KILL. In WAIT with imemValid the same cycle: response discarded, go ISSUE.
- KILL: wait for imemValid, drop data, go ISSUE. Further redirects in KILL update pc only.
- flush: IF/DEC becomes bubble next cycle. A simultaneous imemValid response is dropped. If a request is in flight without imemValid, go KILL.
- hold: pc frozen, IF/DEC becomes bubble, no new imemReq. An in-flight response arriving under hold is captured into a one-entry skid register and presented when hold drops.
- Redirect with hold: the redirect updates pc; hold still suppresses issue.
- Reset: pc=RESET_PC, state ISSUE, PCIF=0, instrIF=NOP_INSTR, validIF=0, imemReq=0, imemAddr=0, misalignTrap=0, skid empty.

## Timing
- Redirect at cycle N: imemReq with the new target no earlier than N+1 (ISSUE), or the cycle after the stale response is dropped (KILL).
- Best-case throughput with 1-cycle memory: one instruction per 2 cycles (ISSUE/WAIT alternation).
- imemReq is registered, never combinational from inputs. Only one request is outstanding at a time.
- Reset mid-WAIT/KILL: the state machine returns to ISSUE next cycle. The environment guarantees no stale imemValid after Reset.

## Configuration
- FETCH_MISALIGN_TRAP_EN defined: a redirect target with [1:0] != 0 sets sticky misalignTrap, enters HALT (no requests, IF/DEC bubbles). Only Reset leaves HALT.
- Undefined: target[1:0] forced to 2'b00. misalignTrap is tied to 0 and HALT is unreachable.

## Test plan
- Reset, RESET_PC=0x100, 1-cycle memory -> requests 0x100, 0x104, 0x108; validIF every other cycle with matching PCIF.
- branch with PCcurrent=0x200, PCnext=0xFFFF_FFF0 during WAIT, response 3 cycles later -> stale response dropped (KILL); next imemAddr=0x1F0; validIF stays 0 until the 0x1F0 data arrives.
- bypass=1 and branch=1 together, PCnext=0x400 -> imemAddr=0x400 (bypass wins).
- hold for 3 cycles while a response arrives -> no imemReq during hold; validIF=0 during hold; the captured instruction appears the cycle after hold drops; pc unchanged.
- flush coincident with imemValid -> instrIF=NOP_INSTR, validIF=0 next cycle; the following fetch is pc+4.
- bypass to 0x302: with FETCH_MISALIGN_TRAP_EN -> misalignTrap=1, no further imemReq until Reset. Without it -> imemAddr=0x300.

Source files
------------

// File: rtl/pc_fetch_unit_if.sv
// Fetch-side bus: redirect bundle in, instruction-memory handshake, IF/DEC register out.
// The fetch unit is the master; decode, branch logic and memory together form the slave side.
interface pc_fetch_unit_if;
   logic        flush;
   logic        hold;
   logic        bypass;
   logic        branch;
   logic [31:0] PCnext;
   logic [31:0] PCcurrent;
   logic        imemReq;
   logic [31:0] imemAddr;
   logic        imemValid;
   logic [31:0] imemRdata;
   logic [31:0] PCIF;
   logic [31:0] instrIF;
   logic        validIF;
   logic        misalignTrap;

   modport master (
      input  flush, hold, bypass, branch, PCnext, PCcurrent, imemValid, imemRdata,
      output imemReq, imemAddr, PCIF, instrIF, validIF, misalignTrap
   );

   modport slave (
      output flush, hold, bypass, branch, PCnext, PCcurrent, imemValid, imemRdata,
      input  imemReq, imemAddr, PCIF, instrIF, validIF, misalignTrap
   );
endinterface

// File: rtl/pc_fetch_unit.sv
// PC and single-outstanding instruction fetch feeding the IF/DEC register.
// Optional feature macro FETCH_MISALIGN_TRAP_EN: misaligned redirect targets trap and halt fetch.
module pc_fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic             i_clk,
   input  logic             i_rst,
   pc_fetch_unit_if.master  bus
);

   typedef enum logic [1:0] {ISSUE, WAIT, KILL, HALT} state_t;

   state_t      r_state;
   logic [31:0] r_pc;
   logic        r_req;
   logic [31:0] r_addr;
   logic [31:0] r_pc_if;
   logic [31:0] r_instr_if;
   logic        r_valid_if;
   logic        r_skid_valid;
   logic [31:0] r_skid_data;
   logic        r_trap;

   state_t      w_state_nxt;
   logic [31:0] w_pc_nxt;
   logic        w_req_nxt;
   logic [31:0] w_addr_nxt;
   logic [31:0] w_pc_if_nxt;
   logic [31:0] w_instr_if_nxt;
   logic        w_valid_if_nxt;
   logic        w_skid_valid_nxt;
   logic [31:0] w_skid_data_nxt;
   logic        w_trap_nxt;

   logic        w_redirect;
   logic [31:0] w_target_raw;
   logic [31:0] w_target;
   logic        w_misalign;
   logic [31:0] w_pc_seq;

   assign w_redirect   = bus.bypass | bus.branch;
   assign w_target_raw = bus.bypass ? bus.PCnext : (bus.PCcurrent + bus.PCnext);
   assign w_pc_seq     = r_pc + 32'd4;

`ifdef FETCH_MISALIGN_TRAP_EN
   assign w_target   = w_target_raw;
   assign w_misalign = w_redirect && (w_target_raw[1:0] != 2'b00);
`else
   assign w_target   = w_target_raw & ~32'h3;
   assign w_misalign = 1'b0;
`endif

   always_comb begin
      // NOTE: every comb output gets a default first so no path can infer a latch.
      w_state_nxt      = r_state;
      w_pc_nxt         = r_pc;
      w_req_nxt        = 1'b0;
      w_addr_nxt       = r_addr;
      w_pc_if_nxt      = r_pc_if;
      w_instr_if_nxt   = NOP_INSTR;
      w_valid_if_nxt   = 1'b0;
      w_skid_valid_nxt = r_skid_valid;
      w_skid_data_nxt  = r_skid_data;
      w_trap_nxt       = r_trap;

      if (r_state != HALT && w_misalign) begin
         w_trap_nxt       = 1'b1;
         w_skid_valid_nxt = 1'b0;
         w_state_nxt      = HALT;
      end else begin
         unique case (r_state)
            ISSUE: begin
               // The skid entry is the instruction at pc, so consuming or dropping it advances pc.
               if (w_redirect) begin
                  w_pc_nxt         = w_target;
                  w_skid_valid_nxt = 1'b0;
               end else if (r_skid_valid && (bus.flush || !bus.hold)) begin
                  w_pc_nxt         = w_pc_seq;
                  w_skid_valid_nxt = 1'b0;
                  if (!bus.flush) begin
                     w_pc_if_nxt    = r_pc;
                     w_instr_if_nxt = r_skid_data;
                     w_valid_if_nxt = 1'b1;
                  end
               end
               if (!bus.hold) begin
                  w_req_nxt   = 1'b1;
                  w_addr_nxt  = w_pc_nxt;
                  w_state_nxt = WAIT;
               end
            end
            WAIT: begin
               if (bus.imemValid) begin
                  if (w_redirect) begin
                     w_pc_nxt    = w_target;
                     w_state_nxt = ISSUE;
                  end else if (bus.flush) begin
                     w_pc_nxt    = w_pc_seq;
                     w_state_nxt = ISSUE;
                  end else if (bus.hold) begin
                     w_skid_valid_nxt = 1'b1;
                     w_skid_data_nxt  = bus.imemRdata;
                     w_state_nxt      = ISSUE;
                  end else begin
                     // Clean response: the next sequential request launches in the same
                     // cycle, folding the ISSUE step in to sustain two cycles per fetch.
                     w_pc_if_nxt    = r_pc;
                     w_instr_if_nxt = bus.imemRdata;
                     w_valid_if_nxt = 1'b1;
                     w_pc_nxt       = w_pc_seq;
                     w_req_nxt      = 1'b1;
                     w_addr_nxt     = w_pc_seq;
                  end
               end else if (w_redirect) begin
                  w_pc_nxt    = w_target;
                  w_state_nxt = KILL;
               end else if (bus.flush) begin
                  w_state_nxt = KILL;
               end
            end
            KILL: begin
               if (w_redirect) w_pc_nxt = w_target;
               if (bus.imemValid) w_state_nxt = ISSUE;
            end
            HALT: begin
               w_state_nxt = HALT;
            end
            default: begin
               w_state_nxt = ISSUE;
            end
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (i_rst) begin
         r_state      <= ISSUE;
         r_pc         <= RESET_PC;
         r_req        <= 1'b0;
         r_addr       <= 32'h0;
         r_pc_if      <= 32'h0;
         r_instr_if   <= NOP_INSTR;
         r_valid_if   <= 1'b0;
         r_skid_valid <= 1'b0;
         r_skid_data  <= NOP_INSTR;
         r_trap       <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_pc         <= w_pc_nxt;
         r_req        <= w_req_nxt;
         r_addr       <= w_addr_nxt;
         r_pc_if      <= w_pc_if_nxt;
         r_instr_if   <= w_instr_if_nxt;
         r_valid_if   <= w_valid_if_nxt;
         r_skid_valid <= w_skid_valid_nxt;
         r_skid_data  <= w_skid_data_nxt;
         r_trap       <= w_trap_nxt;
      end
   end

   assign bus.imemReq      = r_req;
   assign bus.imemAddr     = r_addr;
   assign bus.PCIF         = r_pc_if;
   assign bus.instrIF      = r_instr_if;
   assign bus.validIF      = r_valid_if;
   assign bus.misalignTrap = r_trap;

endmodule
